// File: rtl/control_cmd_queue_if.sv
// Command queue bus: UART bytes, button levels and pop go in; the head command and status come out.
// The queue side uses the slave modport, the producer/consumer side uses master.
interface control_cmd_queue_if #(
   parameter int DEPTH = 16,
   parameter int NBTN  = 4
);
   logic                     uart_valid;
   logic [7:0]               uart_byte;
   logic [NBTN-1:0]          btn;
   logic                     pop;
   logic [2:0]               cmd;
   logic                     cmd_valid;
   logic [$clog2(DEPTH):0]   count;
   logic                     overflow;

   modport master (
      output uart_valid, uart_byte, btn, pop,
      input  cmd, cmd_valid, count, overflow
   );

   modport slave (
      input  uart_valid, uart_byte, btn, pop,
      output cmd, cmd_valid, count, overflow
   );
endinterface

// File: rtl/control_cmd_queue.sv
// Input command queue for the game.
// Merges UART key bytes and debounced buttons into one first-word-fall-through command FIFO.
// Buttons get per-source pending latches and optional auto-repeat, and the FIFO reports dropped
// pushes through a sticky overflow flag.
// Optional build macro CONTROL_QUEUE_COALESCE_EN: a DROP or HOLD push is discarded when the
// tail entry already holds the same code.
module control_cmd_queue #(
   parameter int                  DEPTH         = 16,
   parameter int                  NBTN          = 4,
   parameter logic [3*NBTN-1:0]   BTN_MAP       = 12'h39A,
   parameter logic [NBTN-1:0]     REPEAT_MASK   = 4'b1011,
   parameter int                  REPEAT_DELAY  = 20000000,
   parameter int                  REPEAT_PERIOD = 5000000
) (
   input logic                clk,
   input logic                reset,
   control_cmd_queue_if.slave q
);

   localparam int AW   = $clog2(DEPTH);
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int CW   = $clog2(RMAX + 1);

   localparam logic [2:0] CMD_NONE       = 3'd0;
   localparam logic [2:0] CMD_LEFT       = 3'd1;
   localparam logic [2:0] CMD_RIGHT      = 3'd2;
   localparam logic [2:0] CMD_DOWN       = 3'd3;
   localparam logic [2:0] CMD_DROP       = 3'd4;
   localparam logic [2:0] CMD_HOLD       = 3'd5;
   localparam logic [2:0] CMD_ROTATE     = 3'd6;
   localparam logic [2:0] CMD_ROTATE_REV = 3'd7;

   logic [2:0]      mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW:0]     count_r;
   logic            overflow_r;

   logic [NBTN-1:0] btn_q;
   logic [NBTN-1:0] pend;
   logic [CW-1:0]   rpt_cnt [NBTN];
   logic [NBTN-1:0] rpt_phase;
   logic [NBTN-1:0] rpt_fire;
   logic [NBTN-1:0] btn_rise;
   logic [NBTN-1:0] serve_mask;

   logic [2:0]      uart_code;
   logic [2:0]      push_code;
   logic            push_req;
   logic            do_push;
   logic            do_pop;
   logic            full;
   logic            discard;

   assign btn_rise = q.btn & ~btn_q;

   // Case-insensitive key decode; unknown keys and idle cycles give NONE, which is never pushed.
   always_comb begin
      uart_code = CMD_NONE;
      if (q.uart_valid) begin
         case (q.uart_byte)
            8'h41, 8'h61:        uart_code = CMD_LEFT;
            8'h44, 8'h64:        uart_code = CMD_RIGHT;
            8'h53, 8'h73:        uart_code = CMD_DOWN;
            8'h57, 8'h77, 8'h20: uart_code = CMD_DROP;
            8'h43, 8'h63:        uart_code = CMD_HOLD;
            8'h58, 8'h78:        uart_code = CMD_ROTATE;
            8'h5A, 8'h7A:        uart_code = CMD_ROTATE_REV;
            default:             uart_code = CMD_NONE;
         endcase
      end
   end

   // A held repeating button fires once after the initial delay, then once every period.
   always_comb begin
      rpt_fire = '0;
      for (int i = 0; i < NBTN; i++) begin
         if (REPEAT_MASK[i] && q.btn[i]) begin
            if (rpt_phase[i])
               rpt_fire[i] = (rpt_cnt[i] == CW'(REPEAT_PERIOD));
            else
               rpt_fire[i] = (rpt_cnt[i] == CW'(REPEAT_DELAY));
         end
      end
   end

   // Repeat counters measure how long each button has been held; releasing the button restarts them.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NBTN; i++)
            rpt_cnt[i] <= '0;
         rpt_phase <= '0;
      end else begin
         for (int i = 0; i < NBTN; i++) begin
            if (!q.btn[i] || !REPEAT_MASK[i]) begin
               rpt_cnt[i]   <= '0;
               rpt_phase[i] <= 1'b0;
            end else if (rpt_fire[i]) begin
               rpt_cnt[i]   <= CW'(1);
               rpt_phase[i] <= 1'b1;
            end else begin
               rpt_cnt[i]   <= rpt_cnt[i] + CW'(1);
            end
         end
      end
   end

   // One push per cycle: the UART wins; otherwise the lowest-index pending button is served.
   always_comb begin
      push_req   = 1'b0;
      push_code  = CMD_NONE;
      serve_mask = '0;
      if (uart_code != CMD_NONE) begin
         push_req  = 1'b1;
         push_code = uart_code;
      end else begin
         for (int i = NBTN - 1; i >= 0; i--) begin
            if (pend[i]) begin
               push_req      = 1'b1;
               push_code     = BTN_MAP[3*i +: 3];
               serve_mask    = '0;
               serve_mask[i] = 1'b1;
            end
         end
      end
   end

   // Pending latches hold button events until the arbiter gets a free cycle for them; a held
   // button through reset is reloaded into btn_q so it does not look like a new press.
   always_ff @(posedge clk) begin
      if (reset) begin
         btn_q <= q.btn;
         pend  <= '0;
      end else begin
         btn_q <= q.btn;
         pend  <= (pend & ~serve_mask) | btn_rise | rpt_fire;
      end
   end

`ifdef CONTROL_QUEUE_COALESCE_EN
   logic [2:0] tail_code;

   assign tail_code = mem[wr_ptr - AW'(1)];

   // Repeated DROP/HOLD behind an identical tail entry would be redundant, so it is absorbed.
   always_comb begin
      discard = 1'b0;
      if (push_req && (count_r != '0) && ((push_code == CMD_DROP) || (push_code == CMD_HOLD)))
         discard = (tail_code == push_code);
   end
`else
   assign discard = 1'b0;
`endif

   assign full    = (count_r == (AW + 1)'(DEPTH));
   assign do_pop  = q.pop && (count_r != '0);
   assign do_push = push_req && !discard && (!full || do_pop);

   // Storage array, written at the tail pointer whenever a push is accepted.
   always_ff @(posedge clk) begin
      if (do_push && !reset)
         mem[wr_ptr] <= push_code;
   end

   // Pointer, occupancy and sticky overflow bookkeeping; a full FIFO still accepts a push if a pop
   // frees the head in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_r    <= '0;
         overflow_r <= 1'b0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)
            count_r <= count_r + (AW + 1)'(1);
         else if (!do_push && do_pop)
            count_r <= count_r - (AW + 1)'(1);
         if (push_req && !discard && full && !do_pop)
            overflow_r <= 1'b1;
      end
   end

   assign q.cmd       = (count_r != '0) ? mem[rd_ptr] : CMD_NONE;
   assign q.cmd_valid = (count_r != '0);
   assign q.count     = count_r;
   assign q.overflow  = overflow_r;

endmodule

// File: doc/control_cmd_queue.md
Name: control_cmd_queue

Overview:
- Parametrised successor to the game's input command queue: merges UART key bytes and N debounced buttons into one command FIFO.
- Adds button auto-repeat (delayed auto-shift), per-source pending latches so simultaneous events are never lost, a real head/tail FIFO with an explicit pop strobe, and overflow reporting.
- Sits between input conditioning (uart, debouncers) and the game state machine, which pops one command per WAIT slot.

Parameters:
- DEPTH, 16: FIFO entries; power of two, at least 2.
- NBTN, 4: number of button inputs.
- BTN_MAP, 12'h39A: packed 3-bit command code per button, button i in bits [3i+2:3i]. Default is btn0 RIGHT, btn1 DOWN, btn2 ROTATE, btn3 LEFT.
- REPEAT_MASK, 4'b1011: bit i set means button i auto-repeats.
- REPEAT_DELAY, 20000000: cycles a button is held before its first repeat.
- REPEAT_PERIOD, 5000000: cycles between later repeats.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- uart_valid  in  1  one-cycle strobe: uart_byte is valid.
- uart_byte  in  8  received ASCII byte.
- btn  in  NBTN  debounced button levels.
- pop  in  1  consumer takes the head entry this cycle.
- cmd  out  3  head command code; 0 when empty.
- cmd_valid  out  1  FIFO not empty.
- count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky: a push was dropped because the FIFO was full.

Behaviour:
- Command codes: NONE=0, LEFT=1, RIGHT=2, DOWN=3, DROP=4, HOLD=5, ROTATE=6, ROTATE_REV=7.
- UART decode (case-insensitive):
  - A→LEFT, D→RIGHT, S→DOWN, W or space→DROP, C→HOLD, X→ROTATE, Z→ROTATE_REV.
  - Any other byte decodes to NONE and is never pushed.
- Button events:
  - Rising edge of btn[i] (against a registered copy) sets pend[i].
  - If REPEAT_MASK[i] is set and the button stays high, a per-button counter sets pend[i] again after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles.
  - Counter clears when the button goes low.
  - Setting an already-set pend[i] merges into one event; it does not double.
- Arbitration, at most one push per cycle:
  - A decoded UART command has top priority.
  - Otherwise the lowest-index set pend[i] is served and cleared in the cycle it is pushed.
  - A UART command and a button event in the same cycle: the UART command is pushed now; pend[i] stays set and is pushed on a later free cycle.
- FIFO:
  - First-word fall-through. cmd and cmd_valid are registered-state outputs, with no combinational path from pop.
  - pop while empty is ignored.
  - Push while full with no pop: entry dropped and overflow set to 1. The pend bit is still cleared.
  - Push and pop in the same cycle while full: both succeed and count is unchanged.
  - Push and pop in the same cycle while empty: the push lands and count becomes 1.
  - Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
- Latency:
  - UART strobe at cycle t gives cmd_valid high at t+1 (empty FIFO).
  - Button edge at cycle t: pend[i] is set at t+1 and the command appears at t+2.
- Reset:
  - Clears pointers, count, pend, repeat counters and overflow.
  - The registered btn copy loads the current btn value, so a button held through reset does not generate an edge.
  - Reset mid-operation discards all queued entries.
  - After reset: cmd=0, cmd_valid=0, count=0, overflow=0.

Optional Feature:
- Macro CONTROL_QUEUE_COALESCE_EN.
- When defined: a push of DROP or HOLD is discarded if count>0 and the tail entry (last pushed, not yet popped) holds the same code. A discarded push does not set overflow.
- When undefined: every push is stored as described above.

Test Plan:
- Reset, then uart_valid with byte "a" → one cycle later cmd=1, cmd_valid=1, count=1. Pulse pop → cmd_valid=0, cmd=0.
- uart "x" strobe in the same cycle as a btn[0] rise → entries in order ROTATE(6), RIGHT(2); count=2.
- btn[1] held with REPEAT_DELAY=10, REPEAT_PERIOD=4 → DOWN pushed at press, again at +10 and +14; btn[2] held the same way → exactly one ROTATE.
- DEPTH=4: push 5 UART "d" with no pop → count=4, overflow=1. Then pop and push in the same cycle → count stays 4; after reset overflow=0.
- With CONTROL_QUEUE_COALESCE_EN: "w","w","c","c","w" → queue DROP, HOLD, DROP (count=3). Without the macro → count=5.
- Fill and drain 3×DEPTH alternating codes 1..7 → output order equals input order across pointer wrap.
